// File: rtl/npc_csr_pkg.sv
// Shared CSR addresses, mstatus bit positions, op and sequencer state encodings.
package npc_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    OP_CSRRW = 3'd0,
    OP_CSRRS = 3'd1,
    OP_CSRRC = 3'd2,
    OP_ECALL = 3'd3,
    OP_MRET  = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_T_EPC   = 3'd2,
    ST_T_CAUSE = 3'd3,
    ST_T_STAT  = 3'd4,
    ST_M_EPC   = 3'd5,
    ST_M_STAT  = 3'd6,
    ST_RESP    = 3'd7
  } state_e;

endpackage

// File: rtl/csr_wdata_calc.sv
// Combinational CSR write-data generation: read-modify-write for CSRRW/RS/RC and
// the mstatus transforms applied on trap entry and MRET.
module csr_wdata_calc
  import npc_csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src,
  output logic [XLEN-1:0] rmw_val,
  output logic [XLEN-1:0] trap_mstatus,
  output logic [XLEN-1:0] mret_mstatus
);

  // New CSR value for the instruction forms and the two mstatus transforms
  always_comb begin
    case (op)
      OP_CSRRS: rmw_val = old_val | src;
      OP_CSRRC: rmw_val = old_val & ~src;
      default:  rmw_val = src;
    endcase

    trap_mstatus                                 = old_val;
    trap_mstatus[MSTATUS_MPIE]                   = old_val[MSTATUS_MIE];
    trap_mstatus[MSTATUS_MIE]                    = 1'b0;
    trap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;

    mret_mstatus                                 = old_val;
    mret_mstatus[MSTATUS_MIE]                    = old_val[MSTATUS_MPIE];
    mret_mstatus[MSTATUS_MPIE]                   = 1'b1;
    mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR instruction / ECALL / MRET sequencer in front of a single-write-port CSR file.
// CSR port signals are decoded from the state and latched request fields only.
module csr_access_ctrl
  import npc_csr_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ECALL_CAUSE = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_csr,
  input  logic [XLEN-1:0] req_src,
  input  logic            req_src_zero,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rd,
  output logic            resp_redirect,
  output logic [XLEN-1:0] resp_pc,
  output logic [11:0]     csr_rd_reg,
  input  logic [XLEN-1:0] csr_rd_bus,
  output logic            csr_wr_en,
  output logic [11:0]     csr_wr_reg,
  output logic [XLEN-1:0] csr_wr_bus
);

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [11:0]     csr_q, csr_d;
  logic [XLEN-1:0] src_q, src_d;
  logic            src_zero_q, src_zero_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            redirect_q, redirect_d;

  logic [XLEN-1:0] rmw_val;
  logic [XLEN-1:0] trap_mstatus;
  logic [XLEN-1:0] mret_mstatus;

  csr_wdata_calc #(
    .XLEN (XLEN)
  ) u_wdata_calc (
    .op           (op_q),
    .old_val      (csr_rd_bus),
    .src          (src_q),
    .rmw_val      (rmw_val),
    .trap_mstatus (trap_mstatus),
    .mret_mstatus (mret_mstatus)
  );

  assign req_ready     = (state_q == ST_IDLE);
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_rd       = rd_q;
  assign resp_redirect = redirect_q;
  assign resp_pc       = tgt_q;

  // State register and request/result latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      csr_q      <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      pc_q       <= '0;
      rd_q       <= '0;
      tgt_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      csr_q      <= csr_d;
      src_q      <= src_d;
      src_zero_q <= src_zero_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      tgt_q      <= tgt_d;
      redirect_q <= redirect_d;
    end
  end

  // Next state, latch updates and CSR file port decode
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    csr_d      = csr_q;
    src_d      = src_q;
    src_zero_d = src_zero_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    tgt_d      = tgt_q;
    redirect_d = redirect_q;
    csr_rd_reg = '0;
    csr_wr_en  = 1'b0;
    csr_wr_reg = '0;
    csr_wr_bus = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          csr_d      = req_csr;
          src_d      = req_src;
          src_zero_d = req_src_zero;
          pc_d       = req_pc;
          rd_d       = '0;
          tgt_d      = '0;
          redirect_d = (req_op == OP_ECALL) || (req_op == OP_MRET);
          case (req_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = ST_EXEC;
            OP_ECALL:                     state_d = ST_T_EPC;
            OP_MRET:                      state_d = ST_M_EPC;
            default:                      state_d = ST_RESP;
          endcase
        end
      end
      ST_EXEC: begin
        csr_rd_reg = csr_q;
        rd_d       = csr_rd_bus;
        csr_wr_reg = csr_q;
        csr_wr_bus = rmw_val;
        csr_wr_en  = (op_q == OP_CSRRW) || !src_zero_q;
        state_d    = ST_RESP;
      end
      ST_T_EPC: begin
        csr_rd_reg = CSR_MTVEC;
        tgt_d      = {csr_rd_bus[XLEN-1:2], 2'b00};
        csr_wr_en  = 1'b1;
        csr_wr_reg = CSR_MEPC;
        csr_wr_bus = pc_q;
        state_d    = ST_T_CAUSE;
      end
      ST_T_CAUSE: begin
        csr_wr_en  = 1'b1;
        csr_wr_reg = CSR_MCAUSE;
        csr_wr_bus = XLEN'(ECALL_CAUSE);
        state_d    = ST_T_STAT;
      end
      ST_T_STAT: begin
        csr_rd_reg = CSR_MSTATUS;
        csr_wr_en  = 1'b1;
        csr_wr_reg = CSR_MSTATUS;
        csr_wr_bus = trap_mstatus;
        state_d    = ST_RESP;
      end
      ST_M_EPC: begin
        csr_rd_reg = CSR_MEPC;
        tgt_d      = csr_rd_bus;
        state_d    = ST_M_STAT;
      end
      ST_M_STAT: begin
        csr_rd_reg = CSR_MSTATUS;
        csr_wr_en  = 1'b1;
        csr_wr_reg = CSR_MSTATUS;
        csr_wr_bus = mret_mstatus;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a small CSR file model and a response scoreboard.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_csr;
  logic [31:0] req_src;
  logic        req_src_zero;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rd;
  logic        resp_redirect;
  logic [31:0] resp_pc;
  logic [11:0] csr_rd_reg;
  logic [31:0] csr_rd_bus;
  logic        csr_wr_en;
  logic [11:0] csr_wr_reg;
  logic [31:0] csr_wr_bus;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  csr_access_ctrl #(
    .XLEN        (32),
    .ECALL_CAUSE (11)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_csr       (req_csr),
    .req_src       (req_src),
    .req_src_zero  (req_src_zero),
    .req_pc        (req_pc),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rd       (resp_rd),
    .resp_redirect (resp_redirect),
    .resp_pc       (resp_pc),
    .csr_rd_reg    (csr_rd_reg),
    .csr_rd_bus    (csr_rd_bus),
    .csr_wr_en     (csr_wr_en),
    .csr_wr_reg    (csr_wr_reg),
    .csr_wr_bus    (csr_wr_bus)
  );

  // CSR file model: four implemented registers, combinational read, write on clock edge
  logic [31:0] mstatus = '0, mtvec = '0, mepc = '0, mcause = '0;
  int          wr_count = 0;
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  always_comb begin
    case (csr_rd_reg)
      12'h300: csr_rd_bus = mstatus;
      12'h305: csr_rd_bus = mtvec;
      12'h341: csr_rd_bus = mepc;
      12'h342: csr_rd_bus = mcause;
      default: csr_rd_bus = '0;
    endcase
  end

  always @(posedge clk) begin
    logic [11:0] a;
    logic [31:0] d;
    a = pl_en ? pl_addr : csr_wr_reg;
    d = pl_en ? pl_data : csr_wr_bus;
    if (csr_wr_en) wr_count++;
    if (pl_en || csr_wr_en) begin
      case (a)
        12'h300: mstatus = d;
        12'h305: mtvec   = d;
        12'h341: mepc    = d;
        12'h342: mcause  = d;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [31:0] rd;
    logic [31:0] redir;
    logic [31:0] pc;
    int          lat;
  } sb_t;

  sb_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = addr;
    pl_data = data;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic [2:0] op, input logic [11:0] csr,
                        input logic [31:0] src, input logic zero, input logic [31:0] pc,
                        input logic [31:0] e_rd, input logic e_redir, input logic [31:0] e_pc,
                        input int e_lat, input int e_writes, input int hold);
    sb_t e;
    sb_t got;
    int  lat;
    int  w0;
    e.rd    = e_rd;
    e.redir = 32'(e_redir);
    e.pc    = e_pc;
    e.lat   = e_lat;
    exp_q.push_back(e);
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    w0           = wr_count;
    req_valid    = 1'b1;
    req_op       = op;
    req_csr      = csr;
    req_src      = src;
    req_src_zero = zero;
    req_pc       = pc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    got = exp_q.pop_front();
    check({tag, ".latency"}, 32'(lat), 32'(got.lat));
    check({tag, ".rd"}, resp_rd, got.rd);
    check({tag, ".redirect"}, 32'(resp_redirect), got.redir);
    check({tag, ".pc"}, resp_pc, got.pc);
    if (hold > 0) begin
      resp_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk);
        #1;
        check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, ".hold_rd"}, resp_rd, got.rd);
        check({tag, ".hold_pc"}, resp_pc, got.pc);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, ".resp_done"}, 32'(resp_valid), 32'd0);
    check({tag, ".writes"}, 32'(wr_count - w0), 32'(e_writes));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_op       = '0;
    req_csr      = '0;
    req_src      = '0;
    req_src_zero = 1'b0;
    req_pc       = '0;
    resp_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rd", resp_rd, 32'd0);
    check("rst.resp_redirect", 32'(resp_redirect), 32'd0);
    check("rst.resp_pc", resp_pc, 32'd0);
    check("rst.wr_en", 32'(csr_wr_en), 32'd0);
    check("rst.rd_reg", 32'(csr_rd_reg), 32'd0);
    check("rst.wr_reg", 32'(csr_wr_reg), 32'd0);
    check("rst.wr_bus", csr_wr_bus, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // CSRRW mtvec
    preload(12'h305, 32'h0);
    do_req("rw_mtvec", 3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h0,
           32'h0, 1'b0, 32'h0, 2, 1, 0);
    check("rw_mtvec.mtvec", mtvec, 32'h8000_0100);

    // CSRRS with src_zero: read only
    preload(12'h300, 32'h0000_1800);
    do_req("rs_zero", 3'd1, 12'h300, 32'h8, 1'b1, 32'h0,
           32'h1800, 1'b0, 32'h0, 2, 0, 0);
    check("rs_zero.mstatus", mstatus, 32'h1800);

    // CSRRC clears MPP
    do_req("rc_mstatus", 3'd2, 12'h300, 32'h1800, 1'b0, 32'h0,
           32'h1800, 1'b0, 32'h0, 2, 1, 0);
    check("rc_mstatus.mstatus", mstatus, 32'h0);

    // CSRRS sets bits
    preload(12'h300, 32'h0000_0080);
    do_req("rs_set", 3'd1, 12'h300, 32'h8, 1'b0, 32'h0,
           32'h80, 1'b0, 32'h0, 2, 1, 0);
    check("rs_set.mstatus", mstatus, 32'h88);

    // ECALL trap entry
    preload(12'h305, 32'h8000_0103);
    preload(12'h300, 32'h0000_1808);
    do_req("ecall", 3'd3, 12'h000, 32'h0, 1'b0, 32'h8000_0040,
           32'h0, 1'b1, 32'h8000_0100, 4, 3, 0);
    check("ecall.mepc", mepc, 32'h8000_0040);
    check("ecall.mcause", mcause, 32'd11);
    check("ecall.mstatus", mstatus, 32'h1880);

    // MRET
    preload(12'h341, 32'h8000_0044);
    preload(12'h300, 32'h0000_0080);
    do_req("mret", 3'd4, 12'h000, 32'h0, 1'b0, 32'h0,
           32'h0, 1'b1, 32'h8000_0044, 3, 1, 0);
    check("mret.mstatus", mstatus, 32'h1888);
    check("mret.mepc", mepc, 32'h8000_0044);

    // Back-pressure on a CSRRW of mcause (holds 11 from the trap)
    do_req("bp_rw", 3'd0, 12'h342, 32'h55, 1'b0, 32'h0,
           32'd11, 1'b0, 32'h0, 2, 1, 5);
    check("bp_rw.mcause", mcause, 32'h55);

    // NOP op and unimplemented address
    do_req("nop", 3'd7, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0,
           32'h0, 1'b0, 32'h0, 1, 0, 0);
    do_req("unimpl", 3'd0, 12'h7C0, 32'h1, 1'b0, 32'h0,
           32'h0, 1'b0, 32'h0, 2, 1, 0);

    // Reset during T_CAUSE
    preload(12'h341, 32'h0);
    preload(12'h342, 32'h0000_1234);
    @(negedge clk);
    w0        = wr_count;
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_csr   = '0;
    req_src   = '0;
    req_pc    = 32'h8000_0080;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid.wr_en_before", 32'(csr_wr_en), 32'd1);
    check("rstmid.wr_reg_before", 32'(csr_wr_reg), 32'h342);
    rst_n = 1'b0;
    #1;
    check("rstmid.wr_en_async", 32'(csr_wr_en), 32'd0);
    check("rstmid.req_ready", 32'(req_ready), 32'd1);
    check("rstmid.resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid.mepc", mepc, 32'h8000_0080);
    check("rstmid.mcause", mcause, 32'h1234);
    check("rstmid.writes", 32'(wr_count - w0), 32'd1);

    do_req("post_rst_nop", 3'd5, 12'h000, 32'h0, 1'b0, 32'h0,
           32'h0, 1'b0, 32'h0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
